csa_mult_seq: RTL and testbench
===============================

Name: csa_mult_seq

Overview:
- Iterative unsigned multiplier that owns one `csa` instance of width 2*WIDE and sequences it.
- Adds one shifted partial product per cycle into a carry-save accumulator (sum and carry registers), then resolves with a single carry-propagate add.
- Sits in the multiplier area as the area-lean alternative to an array multiplier.
- Uses valid/ready handshakes on both the input and the output side.

Parameters:
- WIDE, 8, operand width in bits (>= 2). The internal `csa` instance, accumulator registers and product are 2*WIDE wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDE  multiplicand, unsigned.
- b  input  WIDE  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDE  a*b, unsigned.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a rising edge), in effect from the next cycle:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
  - Sum register S, carry register C and step counter cleared; operand registers cleared.
- FSM states: IDLE, ACC, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a into A_r and b into B_r; clear S, C and counter cnt; go to ACC.
- ACC (exactly WIDE cycles, cnt = 0..WIDE-1):
  - pp = B_r[cnt] ? (A_r zero-extended to 2*WIDE) << cnt : 0.
  - `csa` inputs: S, C<<1 (truncated to 2*WIDE bits), pp.
  - S <= ps; C <= pc.
  - cnt increments; after the cnt=WIDE-1 step go to RESOLVE.
  - Invariant: S + 2*C (mod 2^(2*WIDE)) equals the partial sum so far. Truncating the top carry bit is legal because the final product < 2^(2*WIDE).
- RESOLVE (1 cycle): product <= S + (C<<1), truncated to 2*WIDE bits; go to DONE.
- DONE:
  - out_valid=1; product stable.
  - On out_ready go to IDLE (out_valid=0 and in_ready=1 from the next cycle).
  - out_valid must not drop and product must not change while out_ready is low.
- Latency: acceptance edge at T → out_valid high in the cycle after edge T+WIDE+1. That is WIDE+2 cycles from the acceptance cycle to the first out_valid cycle.
- Throughput: one operation per WIDE+3 cycles with out_ready held high (the IDLE cycle is mandatory; no overlap of input acceptance with DONE).
- in_ready=0 in ACC, RESOLVE and DONE. a, b and in_valid are ignored outside IDLE; operand changes during an operation have no effect.
- product holds its last value after the output handshake until the next RESOLVE overwrites it, or until reset.
- Zero operands: the full WIDE steps are still executed (fixed latency, no early termination); result is 0.
- Reset mid-operation (any state): abort immediately to the reset values above; no out_valid is produced for the aborted operation.
- out_ready while not in DONE: ignored.
- Fully synthesizable; no combinational path from in_valid/out_ready to any output except through state.

Test Plan:
- WIDE=8, a=13, b=11, out_ready=1 → in_ready drops the cycle after acceptance; out_valid rises exactly WIDE+2=10 cycles after the acceptance cycle with product=143; returns to IDLE the next cycle.
- WIDE=8, a=255, b=255 → product=65025 (0xFE01). Checks that carry truncation at bit 15 is harmless.
- WIDE=8, a=0,b=200 and then a=200,b=0 → product=0 both times with the same fixed latency of 10.
- Backpressure: a=7, b=9, out_ready low for 5 cycles after out_valid rises → out_valid and product=63 held constant throughout; handshake on out_ready; in_ready=1 the next cycle.
- Back-to-back: in_valid held high with pairs (3,5), (100,200), (17,17) and out_ready=1 → results 15, 20000, 289 in order; one operation per 11 cycles. Operand changes during ACC do not corrupt results.
- Reset mid-ACC: start a=50, b=60, assert rst_n low at cnt=3 for one cycle → out_valid=0, product=0, in_ready=1; a subsequent 6*7 yields 42 with normal latency.
- WIDE=16 regression: a=65535, b=65535 → product=4294836225; out_valid 18 cycles after acceptance.

Source files
------------

// File: rtl/csa_mult_seq.sv
// rtl/csa_mult_seq.sv - iterative unsigned multiplier built on a carry-save accumulator
// One shifted partial product is folded in per cycle; a single carry-propagate add resolves it.

module csa #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);
  assign sum_o   = x_i ^ y_i ^ z_i;
  assign carry_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
endmodule

module csa_mult_seq #(
  parameter int WIDE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE-1:0]   a,
  input  logic [WIDE-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WIDE-1:0] product,
  output logic              busy
);
  localparam int PW = 2 * WIDE;
  localparam int CW = $clog2(WIDE);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDE-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]   s_q, s_d, c_q, c_d, product_q, product_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pp, ps, pc, c_shl;

  // Carries carry weight 2; bit PW-1 is dropped since the true product fits in PW bits.
  assign c_shl = {c_q[PW-2:0], 1'b0};
  assign pp    = b_q[cnt_q] ? ({{WIDE{1'b0}}, a_q} << cnt_q) : '0;

  csa #(.W(PW)) u_csa (
    .x_i     (s_q),
    .y_i     (c_shl),
    .z_i     (pp),
    .sum_o   (ps),
    .carry_o (pc)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        s_d   = ps;
        c_d   = pc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDE - 1)) state_d = RESOLVE;
      end
      RESOLVE: begin
        product_d = s_q + c_shl;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;
endmodule

// File: tb/tb_csa_mult_seq.sv
// tb/tb_csa_mult_seq.sv - directed self-checking bench for csa_mult_seq (WIDE=8 and WIDE=16)

module tb_csa_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  csa_mult_seq #(.WIDE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  csa_mult_seq #(.WIDE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .product(product16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until the 8-bit DUT shows out_valid (bounded).
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  // Drives one operation; latency is counted from the driving negedge.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp);
    int n;
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_low"}, in_ready, 1'b0);
    wait_out(n);
    check({tag, "_latency"}, n + 1, 10);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", product, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_13x11", 8'd13, 8'd11, 16'd143);
    run_op("mul_255x255", 8'd255, 8'd255, 16'hFE01);
    run_op("mul_0x200", 8'd0, 8'd200, 16'd0);
    run_op("mul_200x0", 8'd200, 8'd0, 16'd0);

    // Backpressure: hold DONE for 5 cycles
    in_valid = 1'b1; a = 8'd7; b = 8'd9; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", lat + 1, 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid_hold", out_valid, 1'b1);
      check("bp_product_hold", product, 16'd63);
      check("bp_in_ready_low", in_ready, 1'b0);
      @(negedge clk);
    end
    check("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", {out_valid, in_ready}, 2'b01);
    check("bp_product_kept", product, 16'd63);

    // Back-to-back with in_valid held high; operands change during ACC
    in_valid = 1'b1; a = 8'd3; b = 8'd5;
    @(negedge clk);
    check("b2b_busy", busy, 1'b1);
    a = 8'd100; b = 8'd200;
    wait_out(lat);
    check("b2b_lat1", lat + 1, 10);
    check("b2b_prod1", product, 16'd15);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    a = 8'd17; b = 8'd17;
    wait_out(lat);
    check("b2b_prod2", product, 16'd20000);
    check("b2b_period2", cyc - t0, 11);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 8'd1; b = 8'd1;
    wait_out(lat);
    check("b2b_prod3", product, 16'd289);
    check("b2b_period3", cyc - t0, 11);
    @(negedge clk);

    // Reset mid-ACC at cnt=3
    in_valid = 1'b1; a = 8'd50; b = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_product", product, 16'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    repeat (12) @(negedge clk);
    check("mid_rst_no_result", out_valid, 1'b0);
    run_op("mul_6x7", 8'd6, 8'd7, 16'd42);

    // WIDE=16 regression
    in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("w16_latency", lat, 18);
    check("w16_product", product16, 32'd4294836225);
    @(negedge clk);
    check("w16_back_idle", {out_valid16, in_ready16}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
